// File: rtl/light_sequencer.sv
// Safety sequencer between a light controller and the intersection: enforces pattern hold
// time, an all-Stop clearance before any new movement, and screens illegal signal codes.
module light_sequencer #(
    parameter int CLEAR_CYCLES = 4,
    parameter int MIN_HOLD     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] reqN,
    input  logic [2:0] reqS,
    input  logic [2:0] reqE,
    input  logic [2:0] reqW,
    output logic [2:0] outN,
    output logic [2:0] outS,
    output logic [2:0] outE,
    output logic [2:0] outW,
    output logic       busy,
    output logic       fault,
    output logic       o_dbg_state
);

    localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CLEAR  = 1'b1
    } state_t;

    state_t        r_state;
    logic [11:0]   r_out;
    logic [11:0]   r_latch;
    logic [HW-1:0] r_hold;
    logic [CW-1:0] r_clr;
    logic          r_busy;
    logic          r_fault;

    logic [11:0]   w_raw;
    logic [11:0]   w_tgt;
    logic          w_illegal;
    logic          w_safe;

    assign w_raw = {reqN, reqS, reqE, reqW};

    // Codes above Go (101..111) collapse to Stop; a change is safe when every
    // direction that differs is moving to Stop.
    always_comb begin
        w_tgt     = '0;
        w_illegal = 1'b0;
        w_safe    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_raw[i*3 +: 3] > 3'd4) begin
                w_illegal = 1'b1;
            end else begin
                w_tgt[i*3 +: 3] = w_raw[i*3 +: 3];
            end
        end
        for (int i = 0; i < 4; i++) begin
            if ((w_tgt[i*3 +: 3] != r_out[i*3 +: 3]) && (w_tgt[i*3 +: 3] != 3'd0)) begin
                w_safe = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_STABLE;
            r_out   <= '0;
            r_latch <= '0;
            r_hold  <= '0;
            r_clr   <= '0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            if (w_illegal) begin
                r_fault <= 1'b1;
            end
            case (r_state)
                ST_STABLE: begin
                    if (w_tgt == r_out) begin
                        if (r_hold != HOLD_MAX) begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end else if (w_safe) begin
                        r_out  <= w_tgt;
                        r_hold <= '0;
                    end else if (r_hold == HOLD_MAX) begin
                        r_hold <= '0;
                        if (r_out == '0) begin
                            r_out <= w_tgt;
                        end else begin
                            r_latch <= w_tgt;
                            r_out   <= '0;
                            r_busy  <= 1'b1;
                            r_clr   <= '0;
                            r_state <= ST_CLEAR;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // Requests are ignored here; only the latched target leaves clearance.
                    if (r_clr == CLR_LAST) begin
                        r_out   <= r_latch;
                        r_busy  <= 1'b0;
                        r_hold  <= '0;
                        r_clr   <= '0;
                        r_state <= ST_STABLE;
                    end else begin
                        r_clr <= r_clr + 1'b1;
                    end
                end
                default: r_state <= ST_STABLE;
            endcase
        end
    end

    assign outN        = r_out[11:9];
    assign outS        = r_out[8:6];
    assign outE        = r_out[5:3];
    assign outW        = r_out[2:0];
    assign busy        = r_busy;
    assign fault       = r_fault;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed-vector bench for light_sequencer: a driver pushes hand-computed expected outputs
// into a queue and a monitor pops and compares after each clock edge or reset assertion.
module tb_light_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] reqN = 3'd0;
    logic [2:0] reqS = 3'd0;
    logic [2:0] reqE = 3'd0;
    logic [2:0] reqW = 3'd0;
    logic [2:0] outN, outS, outE, outW;
    logic       busy, fault, o_dbg_state;

    logic [13:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;
    string       phase = "init";
    bit          drv_done = 1'b0;

    light_sequencer #(.CLEAR_CYCLES(4), .MIN_HOLD(8)) dut (
        .clk(clk), .rst(rst),
        .reqN(reqN), .reqS(reqS), .reqE(reqE), .reqW(reqW),
        .outN(outN), .outS(outS), .outE(outE), .outW(outW),
        .busy(busy), .fault(fault), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    // One row: drive inputs on the falling edge, expect {outs, busy, fault} after the next
    // rising edge. A rising rst also queues a check right after assertion.
    task automatic step(input bit r, input logic [11:0] req, input logic [11:0] eo,
                        input bit eb, input bit ef);
        @(negedge clk);
        reqN = req[11:9];
        reqS = req[8:6];
        reqE = req[5:3];
        reqW = req[2:0];
        if (r && !rst) begin
            exp_q.push_back({eo, eb, ef});
            name_q.push_back({phase, "_async"});
        end
        exp_q.push_back({eo, eb, ef});
        name_q.push_back(phase);
        rst = r;
    endtask

    task automatic run(input int k, input bit r, input logic [11:0] req,
                       input logic [11:0] eo, input bit eb, input bit ef);
        for (int i = 0; i < k; i++) begin
            step(r, req, eo, eb, ef);
        end
    endtask

    initial begin : monitor
        logic [13:0] got;
        logic [13:0] want;
        string       nm;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                nm   = name_q.pop_front();
                got  = {outN, outS, outE, outW, busy, fault};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL %s at %0t: got N=%o S=%o E=%o W=%o busy=%b fault=%b, want N=%o S=%o E=%o W=%o busy=%b fault=%b",
                             nm, $time, got[13:11], got[10:8], got[7:5], got[4:2], got[1], got[0],
                             want[13:11], want[10:8], want[7:5], want[4:2], want[1], want[0]);
                end
            end
        end
    end

    initial begin : driver
        phase = "reset";
        step(1'b1, 12'($urandom_range(0, 4095)), 12'o0000, 1'b0, 1'b0);
        step(1'b1, 12'($urandom_range(0, 4095)), 12'o0000, 1'b0, 1'b0);

        phase = "hold_after_rst";
        run(8, 1'b0, 12'o4000, 12'o0000, 1'b0, 1'b0);
        run(1, 1'b0, 12'o4000, 12'o4000, 1'b0, 1'b0);

        phase = "safe_change";
        run(1, 1'b0, 12'o0000, 12'o0000, 1'b0, 1'b0);

        phase = "reapply";
        run(8, 1'b0, 12'o4000, 12'o0000, 1'b0, 1'b0);
        run(1, 1'b0, 12'o4000, 12'o4000, 1'b0, 1'b0);

        phase = "hold_enforce";
        run(1, 1'b0, 12'o4000, 12'o4000, 1'b0, 1'b0);
        run(7, 1'b0, 12'o4100, 12'o4000, 1'b0, 1'b0);
        run(1, 1'b0, 12'o4100, 12'o0000, 1'b1, 1'b0);
        run(3, 1'b0, 12'o0003, 12'o0000, 1'b1, 1'b0);
        run(1, 1'b0, 12'o0040, 12'o4100, 1'b0, 1'b0);

        phase = "conflict";
        run(8, 1'b0, 12'o0040, 12'o4100, 1'b0, 1'b0);
        run(4, 1'b0, 12'o0040, 12'o0000, 1'b1, 1'b0);
        run(1, 1'b0, 12'o0040, 12'o0040, 1'b0, 1'b0);

        phase = "illegal";
        run(1, 1'b0, 12'o0006, 12'o0000, 1'b0, 1'b1);
        run(2, 1'b0, 12'o0000, 12'o0000, 1'b0, 1'b1);

        phase = "rearm";
        run(6, 1'b0, 12'o4000, 12'o0000, 1'b0, 1'b1);
        run(1, 1'b0, 12'o4000, 12'o4000, 1'b0, 1'b1);

        phase = "mid_clear";
        run(8, 1'b0, 12'o0400, 12'o4000, 1'b0, 1'b1);
        run(2, 1'b0, 12'o0400, 12'o0000, 1'b1, 1'b1);
        run(1, 1'b1, 12'o0400, 12'o0000, 1'b0, 1'b0);
        run(12, 1'b0, 12'o0000, 12'o0000, 1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        drv_done = 1'b1;
    end

    initial begin : finisher
        fork
            wait (drv_done);
            #100000;
        join_any
        if (!drv_done) begin
            total++;
            bad++;
            $display("FAIL timeout: driver did not complete, required completion by %0t", $time);
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
